uart_tx_fifo_cfg: RTL
=====================

Name: uart_tx_fifo_cfg

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 baud-clocked TX. Runs on the system clock with an internal baud divider. Accepts words over a valid/ready stream into a small FIFO. Serialises them with run-time selectable parity and 1/2 stop bits, and feeds the board TX pin for result readback from the matrix-multiply datapath.

Parameters:
CLKS_PER_BIT, 868, system clocks per serial bit (>=2); 868 = 100 MHz / 115200
DATA_BITS, 8, payload bits per frame (5..9)
FIFO_DEPTH, 4, entries in input FIFO (power of 2, >=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
s_data  in  DATA_BITS  word to transmit
s_valid  in  1  s_data valid
s_ready  out  1  FIFO can accept; transfer when s_valid && s_ready on a rising edge
parity_en  in  1  1 = append parity bit
parity_odd  in  1  1 = odd parity, 0 = even (ignored when parity_en=0)
two_stop  in  1  1 = two stop bits, 0 = one
tx  out  1  serial line, idle high
busy  out  1  frame in progress
fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=0, async) values: tx=1, busy=0, s_ready=1 after release, fifo_count=0, FSM=IDLE, baud counter=0. FIFO contents discarded. Reset mid-frame aborts the frame immediately; tx goes high asynchronously.
- FIFO:
  - Push when s_valid && s_ready. s_ready = (fifo_count != FIFO_DEPTH), registered-state based, no combinational path from s_valid.
  - Pop by FSM only. Push and pop in the same cycle are legal even when full: count unchanged, but s_ready was already 0, so no push happens when full.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1, busy=0. If FIFO non-empty: pop, latch word into shift reg, latch parity_en/parity_odd/two_stop, go to START. tx=0 and busy=1 from the next cycle.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: LSB first. Each bit held CLKS_PER_BIT cycles. After DATA_BITS bits go to PARITY if the latched parity_en is set, else STOP.
  - PARITY: tx = XOR of the data bits XOR parity_odd, held CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT, or 2*CLKS_PER_BIT if two_stop is latched. At the last stop cycle: if FIFO non-empty, pop and go directly to START (busy stays 1, no idle gap). Else go to IDLE (busy=0 next cycle).
- Frame length = (1 + DATA_BITS + P + S) * CLKS_PER_BIT cycles, P ∈ {0,1}, S ∈ {1,2}. Tolerance is exact; no jitter.
- Config inputs changed mid-frame affect only the next frame.
- Baud counter: 0..CLKS_PER_BIT-1, reset to 0 on every state transition; bit boundary at terminal count. Data bit index counter is $clog2(DATA_BITS+1) wide.
- tx is a registered output, glitch-free.
- Latency: a push into an empty FIFO while IDLE gives the tx falling edge 2 cycles after the push edge: push edge → FIFO non-empty → IDLE pops → tx=0.

Decomposition:
- Shared package uart_pkg: FSM state enum (IDLE/START/DATA/PARITY/STOP), parity-mode constants, function computing frame length from DATA_BITS/parity/stop settings (used by RTL assertions and bench).
- One sub-module: uart_sync_fifo (DEPTH, WIDTH parameters; push/pop/full/empty/count). It is reusable by the planned uart_rx_fifo_cfg.

Test Plan:
- CLKS_PER_BIT=4, DATA_BITS=8, parity off, 1 stop; push 0xA5 → tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; busy high for exactly 40 cycles; tx falls 2 cycles after push.
- Same, parity_en=1, parity_odd=0, push 0xA5 → parity bit 0, frame 44 cycles. parity_odd=1 → parity bit 1. Push 0x01 even → parity bit 1.
- two_stop=1, push 0x00 then 0xFF back-to-back → stop high 8 cycles, second start bit immediately after; busy never drops between frames; total 2×44 cycles (no parity).
- FIFO_DEPTH=4, hold s_valid=1 with 6 distinct words from idle → first popped, 4 stored, s_ready=0 on the 6th until a pop; all 6 words appear on tx in order, none lost or duplicated.
- Assert rst=0 in DATA bit 3 of a frame with 2 words queued → tx=1 and busy=0 immediately, fifo_count=0. After release, tx stays 1 with no spurious frame.
- DATA_BITS=5, CLKS_PER_BIT=2, push 5'b10110 → bits 0,1,1,0,1 after start; frame 14 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter and the planned receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Serial frame length in system clocks for a given frame format.
    function automatic int unsigned frame_len(input int unsigned clks_per_bit,
                                              input int unsigned data_bits,
                                              input logic        parity_en,
                                              input logic        two_stop);
        return (32'd1 + data_bits + 32'(parity_en) + (two_stop ? 32'd2 : 32'd1)) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO with registered full/empty/count flags.
module uart_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata_c,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_d;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata_c = mem[rd_ptr];

    always_comb begin
        count_d = count;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count + CW'(1);
            2'b01:   count_d = count - CW'(1);
            default: count_d = count;
        endcase
    end

    // Storage is not reset; only pointers and occupancy define valid contents.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_d;
            full  <= (count_d == CW'(DEPTH));
            empty <= (count_d == CW'(0));
        end
    end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter with input FIFO, internal baud divider and run-time frame format.
module uart_tx_fifo_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          two_stop,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(DATA_BITS + 1);

    tx_state_e            state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 pen_q, pen_d;
    logic                 pbit_q, pbit_d;
    logic                 two_q, two_d;
    logic                 tx_d;
    logic                 start_frame;
    logic                 frame_end_c;
    logic                 baud_done;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;
    int unsigned          frame_cnt_q;

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (s_valid),
        .pop     (start_frame),
        .wdata   (s_data),
        .rdata_c (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign s_ready   = !fifo_full;
    assign baud_done = (baud_q == BW'(CLKS_PER_BIT - 1));

    // Next-state, datapath and line-level decode; a pop loads the next frame.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        pen_d       = pen_q;
        pbit_d      = pbit_q;
        two_d       = two_q;
        tx_d        = 1'b1;
        start_frame = 1'b0;
        frame_end_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d      = '0;
                idx_d       = '0;
                start_frame = !fifo_empty;
            end
            ST_START: begin
                tx_d = 1'b0;
                if (baud_done) begin
                    state_d = ST_DATA;
                    baud_d  = '0;
                    idx_d   = '0;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == IW'(DATA_BITS - 1)) begin
                        idx_d   = '0;
                        state_d = pen_q ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            ST_PARITY: begin
                tx_d = pbit_q;
                if (baud_done) begin
                    state_d = ST_STOP;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (two_q && idx_q == IW'(0)) begin
                        idx_d = IW'(1);
                    end else begin
                        idx_d       = '0;
                        frame_end_c = 1'b1;
                        state_d     = ST_IDLE;
                        start_frame = !fifo_empty;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (start_frame) begin
            state_d = ST_START;
            baud_d  = '0;
            idx_d   = '0;
            shift_d = fifo_rdata;
            pen_d   = parity_en;
            pbit_d  = (^fifo_rdata) ^ parity_odd;
            two_d   = two_stop;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            pen_q   <= 1'b0;
            pbit_q  <= 1'b0;
            two_q   <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            pen_q   <= pen_d;
            pbit_q  <= pbit_d;
            two_q   <= two_d;
            tx      <= tx_d;
            busy    <= (state_q != ST_IDLE);
        end
    end

    // Frame-length tracker feeding the exact-timing assertion below.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= '0;
        end else if (start_frame) begin
            frame_cnt_q <= '0;
        end else if (state_q != ST_IDLE) begin
            frame_cnt_q <= frame_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && frame_end_c) begin
            assert (frame_cnt_q == frame_len(CLKS_PER_BIT, DATA_BITS, pen_q, two_q) - 32'd1);
        end
    end

endmodule
